// File: rtl/vc_fifo_pkg.sv
// Shared width helpers for the multi-channel circular FIFO.
// Used by the interface, the per-channel controller and the top level.
package vc_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned DEPTH_WIDTH_DEF = 2;
  localparam int unsigned VC_NUM_DEF      = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < n; p = p << 1) r++;
    return r;
  endfunction

  // A single channel still needs a one-bit select
  function automatic int unsigned vc_w(input int unsigned vc_num);
    return (vc_num <= 1) ? 1 : clog2(vc_num);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

  function automatic int unsigned cnt_lsb(input int unsigned vc, input int unsigned depth_width);
    return vc * (depth_width + 1);
  endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Write/read/status bundle of the multi-channel FIFO.
// The master drives requests; the slave (the FIFO) returns data and status.
interface vc_fifo_if
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH_WIDTH = DEPTH_WIDTH_DEF,
  parameter int unsigned VC_NUM      = VC_NUM_DEF
);
  localparam int unsigned VC_W  = vc_w(VC_NUM);
  localparam int unsigned CNT_W = cnt_w(DEPTH_WIDTH);

  logic                    wr_en_i;
  logic [VC_W-1:0]         wr_vc_i;
  logic [DATA_WIDTH-1:0]   data_i;
  logic                    rd_en_i;
  logic [VC_W-1:0]         rd_vc_i;
  logic                    err_clr_i;
  logic [DATA_WIDTH-1:0]   data_o;
  logic [VC_NUM-1:0]       full_o;
  logic [VC_NUM-1:0]       empty_o;
  logic [VC_NUM-1:0]       almost_full_o;
  logic [VC_NUM-1:0]       almost_empty_o;
  logic [VC_NUM*CNT_W-1:0] count_o;
  logic [VC_NUM-1:0]       overflow_o;
  logic [VC_NUM-1:0]       underflow_o;

  modport master (
    output wr_en_i, wr_vc_i, data_i, rd_en_i, rd_vc_i, err_clr_i,
    input  data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, wr_vc_i, data_i, rd_en_i, rd_vc_i, err_clr_i,
    output data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/vc_fifo_ctrl.sv
// Per-channel pointer and status controller: wrap-bit pointers, occupancy,
// almost flags and sticky overflow/underflow.
module vc_fifo_ctrl
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH        = DEPTH_WIDTH_DEF,
  parameter int unsigned ALMOST_FULL_LEVEL  = (1 << DEPTH_WIDTH) - 1,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
  localparam int unsigned CNT_W             = cnt_w(DEPTH_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_wr_req,
  input  logic                   i_rd_req,
  input  logic                   i_err_clr,
  output logic                   o_wr_acc_c,
  output logic                   o_rd_acc_c,
  output logic [DEPTH_WIDTH-1:0] o_wr_idx,
  output logic [DEPTH_WIDTH-1:0] o_rd_idx,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic                   o_afull_c,
  output logic                   o_aempty_c,
  output logic [CNT_W-1:0]       o_count_c,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CNT_W-1:0] w_count;

  // Status is purely a function of the registered pointers
  always_comb begin
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (r_wr_ptr[DEPTH_WIDTH-1:0] == r_rd_ptr[DEPTH_WIDTH-1:0]) &&
               (r_wr_ptr[DEPTH_WIDTH] != r_rd_ptr[DEPTH_WIDTH]);
    w_count  = r_wr_ptr - r_rd_ptr;
    w_rd_acc = i_rd_req && !w_empty;
    // A pop on a full channel frees the slot the push lands in
    w_wr_acc = i_wr_req && (!w_full || w_rd_acc);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      r_overflow  <= (r_overflow  && !i_err_clr) || (i_wr_req && !w_wr_acc);
      r_underflow <= (r_underflow && !i_err_clr) || (i_rd_req && !w_rd_acc);
    end
  end

  assign o_wr_acc_c  = w_wr_acc;
  assign o_rd_acc_c  = w_rd_acc;
  assign o_wr_idx    = r_wr_ptr[DEPTH_WIDTH-1:0];
  assign o_rd_idx    = r_rd_ptr[DEPTH_WIDTH-1:0];
  assign o_full_c    = w_full;
  assign o_empty_c   = w_empty;
  assign o_count_c   = w_count;
  assign o_afull_c   = (w_count >= CNT_W'(ALMOST_FULL_LEVEL));
  assign o_aempty_c  = (w_count <= CNT_W'(ALMOST_EMPTY_LEVEL));
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/vc_fifo.sv
// Multi-channel FWFT circular FIFO: shared storage, channel decode and
// head-flit mux around one vc_fifo_ctrl per virtual channel.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH_WIDTH        = DEPTH_WIDTH_DEF,
  parameter int unsigned VC_NUM             = VC_NUM_DEF,
  parameter int unsigned ALMOST_FULL_LEVEL  = (1 << DEPTH_WIDTH) - 1,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
  input logic     clk_i,
  input logic     rst_ni,
  vc_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam int unsigned VC_W  = vc_w(VC_NUM);
  localparam int unsigned CNT_W = cnt_w(DEPTH_WIDTH);

  logic [DATA_WIDTH-1:0]  r_mem [VC_NUM][DEPTH];
  logic [VC_NUM-1:0]      w_wr_sel;
  logic [VC_NUM-1:0]      w_rd_sel;
  logic [VC_NUM-1:0]      w_wr_acc;
  logic [VC_NUM-1:0]      w_rd_acc;
  logic [DEPTH_WIDTH-1:0] w_wr_idx [VC_NUM];
  logic [DEPTH_WIDTH-1:0] w_rd_idx [VC_NUM];
  logic [DATA_WIDTH-1:0]  w_data;

  // Out-of-range channel indices match no channel and are dropped silently
  always_comb begin
    w_wr_sel = '0;
    w_rd_sel = '0;
    for (int v = 0; v < int'(VC_NUM); v++) begin
      w_wr_sel[v] = bus.wr_en_i && (bus.wr_vc_i == VC_W'(v));
      w_rd_sel[v] = bus.rd_en_i && (bus.rd_vc_i == VC_W'(v));
    end
  end

  for (genvar v = 0; v < int'(VC_NUM); v++) begin : g_vc
    vc_fifo_ctrl #(
      .DEPTH_WIDTH        (DEPTH_WIDTH),
      .ALMOST_FULL_LEVEL  (ALMOST_FULL_LEVEL),
      .ALMOST_EMPTY_LEVEL (ALMOST_EMPTY_LEVEL)
    ) u_ctrl (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_wr_req    (w_wr_sel[v]),
      .i_rd_req    (w_rd_sel[v]),
      .i_err_clr   (bus.err_clr_i),
      .o_wr_acc_c  (w_wr_acc[v]),
      .o_rd_acc_c  (w_rd_acc[v]),
      .o_wr_idx    (w_wr_idx[v]),
      .o_rd_idx    (w_rd_idx[v]),
      .o_full_c    (bus.full_o[v]),
      .o_empty_c   (bus.empty_o[v]),
      .o_afull_c   (bus.almost_full_o[v]),
      .o_aempty_c  (bus.almost_empty_o[v]),
      .o_count_c   (bus.count_o[cnt_lsb(v, DEPTH_WIDTH) +: CNT_W]),
      .o_overflow  (bus.overflow_o[v]),
      .o_underflow (bus.underflow_o[v])
    );
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone
  always_ff @(posedge clk_i) begin
    for (int v = 0; v < int'(VC_NUM); v++) begin
      if (w_wr_acc[v]) r_mem[v][w_wr_idx[v]] <= bus.data_i;
    end
  end

  always_comb begin
    w_data = '0;
    for (int v = 0; v < int'(VC_NUM); v++) begin
      if (bus.rd_vc_i == VC_W'(v)) w_data = r_mem[v][w_rd_idx[v]];
    end
  end

  assign bus.data_o = w_data;

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo (DEPTH_WIDTH=2, VC_NUM=2) with immediate-assertion checks.
module tb_vc_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned NV = 2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [7:0] q [$];
  logic [7:0] nd;

  vc_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .VC_NUM(NV)) bus ();

  vc_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .VC_NUM(NV)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en_i   = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.err_clr_i = 1'b0;
  endtask

  task automatic wr(input logic vc, input logic [7:0] d);
    bus.wr_en_i = 1'b1;
    bus.wr_vc_i = vc;
    bus.data_i  = d;
    cyc();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic pop(input logic vc, input logic [7:0] exp_head, input string tag);
    bus.rd_vc_i = vc;
    #1;
    chk(tag, 32'(bus.data_o), 32'(exp_head));
    bus.rd_en_i = 1'b1;
    cyc();
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    bus.wr_vc_i = '0;
    bus.rd_vc_i = '0;
    bus.data_i  = '0;
    #12 rst_n = 1'b1;
    cyc();

    chk("rst_empty",  32'(bus.empty_o),        32'h3);
    chk("rst_full",   32'(bus.full_o),         32'h0);
    chk("rst_aempty", 32'(bus.almost_empty_o), 32'h3);
    chk("rst_afull",  32'(bus.almost_full_o),  32'h0);
    chk("rst_count",  32'(bus.count_o),        32'h0);
    chk("rst_ovf",    32'(bus.overflow_o),     32'h0);
    chk("rst_unf",    32'(bus.underflow_o),    32'h0);

    // Fill VC0, then push once more into the full channel
    wr(1'b0, 8'h11);
    wr(1'b0, 8'h22);
    wr(1'b0, 8'h33);
    chk("fill3_afull", 32'(bus.almost_full_o), 32'h1);
    chk("fill3_count", 32'(bus.count_o),       32'h03);
    wr(1'b0, 8'h44);
    chk("fill4_full",   32'(bus.full_o),         32'h1);
    chk("fill4_count",  32'(bus.count_o),        32'h04);
    chk("fill4_empty",  32'(bus.empty_o),        32'h2);
    chk("fill4_aempty", 32'(bus.almost_empty_o), 32'h2);
    wr(1'b0, 8'h55);
    chk("ovf_flag",  32'(bus.overflow_o), 32'h1);
    chk("ovf_count", 32'(bus.count_o),    32'h04);

    // Drain VC0 in order, then underflow, then clear flags
    pop(1'b0, 8'h11, "pop0");
    pop(1'b0, 8'h22, "pop1");
    pop(1'b0, 8'h33, "pop2");
    pop(1'b0, 8'h44, "pop3");
    chk("drain_empty", 32'(bus.empty_o), 32'h3);
    chk("drain_count", 32'(bus.count_o), 32'h0);
    bus.rd_en_i = 1'b1;
    cyc();
    bus.rd_en_i = 1'b0;
    chk("unf_flag", 32'(bus.underflow_o), 32'h1);
    bus.err_clr_i = 1'b1;
    cyc();
    bus.err_clr_i = 1'b0;
    chk("clr_ovf", 32'(bus.overflow_o),  32'h0);
    chk("clr_unf", 32'(bus.underflow_o), 32'h0);

    // Interleaved channels
    wr(1'b0, 8'hA0);
    wr(1'b1, 8'hB0);
    wr(1'b0, 8'hA1);
    bus.rd_vc_i = 1'b1;
    #1 chk("il_head1", 32'(bus.data_o), 32'hB0);
    bus.rd_vc_i = 1'b0;
    #1 chk("il_head0", 32'(bus.data_o), 32'hA0);
    chk("il_count", 32'(bus.count_o), 32'h0A);
    pop(1'b0, 8'hA0, "il_pop0a");
    pop(1'b0, 8'hA1, "il_pop0b");
    pop(1'b1, 8'hB0, "il_pop1");
    chk("il_empty", 32'(bus.empty_o), 32'h3);

    // VC1 full with simultaneous push+pop, then wrap for 10 cycles
    wr(1'b1, 8'hC0);
    wr(1'b1, 8'hC1);
    wr(1'b1, 8'hC2);
    wr(1'b1, 8'hC3);
    chk("vc1_full", 32'(bus.full_o), 32'h2);
    bus.rd_vc_i = 1'b1;
    #1 chk("fullrw_head", 32'(bus.data_o), 32'hC0);
    bus.wr_en_i = 1'b1; bus.wr_vc_i = 1'b1; bus.data_i = 8'hEE;
    bus.rd_en_i = 1'b1;
    cyc();
    idle();
    chk("fullrw_count", 32'(bus.count_o),    32'h20);
    chk("fullrw_ovf",   32'(bus.overflow_o), 32'h0);
    chk("fullrw_head2", 32'(bus.data_o),     32'hC1);
    q = '{8'hC1, 8'hC2, 8'hC3, 8'hEE};
    for (int i = 0; i < 10; i++) begin
      nd = 8'(8'hF0 + i);
      chk("wrap_head", 32'(bus.data_o), 32'(q[0]));
      bus.wr_en_i = 1'b1; bus.wr_vc_i = 1'b1; bus.data_i = nd;
      bus.rd_en_i = 1'b1;
      cyc();
      void'(q.pop_front());
      q.push_back(nd);
    end
    idle();
    chk("wrap_head_end", 32'(bus.data_o),     32'(q[0]));
    chk("wrap_count",    32'(bus.count_o),    32'h20);
    chk("wrap_ovf",      32'(bus.overflow_o), 32'h0);

    // VC0 empty with simultaneous push+pop: no bypass
    bus.wr_en_i = 1'b1; bus.wr_vc_i = 1'b0; bus.data_i = 8'h77;
    bus.rd_en_i = 1'b1; bus.rd_vc_i = 1'b0;
    cyc();
    idle();
    chk("emptyrw_unf",   32'(bus.underflow_o), 32'h1);
    chk("emptyrw_data",  32'(bus.data_o),      32'h77);
    chk("emptyrw_count", 32'(bus.count_o),     32'h21);

    // Clear and a fresh overflow on VC1 in the same cycle: set wins
    bus.err_clr_i = 1'b1;
    bus.wr_en_i = 1'b1; bus.wr_vc_i = 1'b1; bus.data_i = 8'h99;
    cyc();
    idle();
    chk("clrset_ovf", 32'(bus.overflow_o),  32'h2);
    chk("clrset_unf", 32'(bus.underflow_o), 32'h0);

    // Fill VC0 to 3 then reset asynchronously mid-cycle
    wr(1'b0, 8'h78);
    wr(1'b0, 8'h79);
    chk("pre_rst_afull", 32'(bus.almost_full_o), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty",  32'(bus.empty_o),        32'h3);
    chk("arst_full",   32'(bus.full_o),         32'h0);
    chk("arst_afull",  32'(bus.almost_full_o),  32'h0);
    chk("arst_aempty", 32'(bus.almost_empty_o), 32'h3);
    chk("arst_count",  32'(bus.count_o),        32'h0);
    chk("arst_ovf",    32'(bus.overflow_o),     32'h0);
    chk("arst_unf",    32'(bus.underflow_o),    32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_empty", 32'(bus.empty_o), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
